// File: rtl/regfile_write_queue.sv
// In-order write queue feeding the register file write port (C/rc/le),
// with load-over-ALU enqueue priority and read-after-write hazard flags.
module regfile_write_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [3:0]               alu_rd,
  input  logic [31:0]              alu_data,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [3:0]               ld_rd,
  input  logic [31:0]              ld_data,
  input  logic                     stall,
  output logic [31:0]              C,
  output logic [3:0]               rc,
  output logic                     le,
  input  logic [3:0]               ra,
  input  logic [3:0]               rb,
  output logic                     hz_a,
  output logic                     hz_b,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [3:0]    rd_q   [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          full;
  logic          empty;
  logic          enq;
  logic          deq;
  logic [3:0]    enq_rd;
  logic [31:0]   enq_data;
  logic [AW-1:0]    off [DEPTH];
  logic [DEPTH-1:0] vld;

  // Ready depends only on registered count, so a same-cycle dequeue never frees a slot.
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign ld_ready  = ~full;
  assign alu_ready = ~full & ~ld_valid;

  assign enq      = (ld_valid & ld_ready) | (alu_valid & alu_ready);
  assign enq_rd   = ld_valid ? ld_rd   : alu_rd;
  assign enq_data = ld_valid ? ld_data : alu_data;
  assign deq      = ~empty & ~stall;

  assign le    = ~deq;
  assign C     = empty ? 32'd0 : data_q[head_q];
  assign rc    = empty ? 4'd0  : rd_q[head_q];
  assign count = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq) tail_d = tail_q + AW'(1);
    if (deq) head_d = head_q + AW'(1);
    case ({enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr && enq) begin
      rd_q[tail_q]   <= enq_rd;
      data_q[tail_q] <= enq_data;
    end
  end

  // An entry is live when its distance from head is below count; this includes the head being written.
  always_comb begin
    hz_a = 1'b0;
    hz_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      off[i] = AW'(i) - head_q;
      vld[i] = ({1'b0, off[i]} < count_q);
      if (vld[i] && rd_q[i] == ra) hz_a = 1'b1;
      if (vld[i] && rd_q[i] == rb) hz_b = 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed bench for regfile_write_queue: inputs change 1 ns after the rising
// edge, outputs are sampled on the falling edge against hand-computed values.
module tb_regfile_write_queue;

  logic        clk = 1'b0;
  logic        clr;
  logic        alu_valid, alu_ready;
  logic [3:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid, ld_ready;
  logic [3:0]  ld_rd;
  logic [31:0] ld_data;
  logic        stall;
  logic [31:0] C;
  logic [3:0]  rc;
  logic        le;
  logic [3:0]  ra, rb;
  logic        hz_a, hz_b;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_write_queue #(.DEPTH(4)) dut (
    .clk(clk), .clr(clr),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .stall(stall), .C(C), .rc(rc), .le(le),
    .ra(ra), .rb(rb), .hz_a(hz_a), .hz_b(hz_b), .count(count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_le"},    32'(le),    32'd1);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_rc"},    32'(rc),    32'd0);
    check({tag, "_C"},     C,          32'd0);
  endtask

  initial begin
    clr = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0; stall = 1'b0;
    ra = 4'd0; rb = 4'd0;
    next_cycle();
    clr = 1'b0;

    // reset state
    sample();
    check_idle("rst");
    check("rst_hz_a", 32'(hz_a), 32'd0);
    check("rst_hz_b", 32'(hz_b), 32'd0);
    check("rst_alu_ready", 32'(alu_ready), 32'd1);
    check("rst_ld_ready",  32'(ld_ready),  32'd1);
    next_cycle();

    // single write
    ld_valid = 1'b1; ld_rd = 4'd5; ld_data = 32'hDEADBEEF;
    sample();
    check("sw_ld_ready", 32'(ld_ready), 32'd1);
    check("sw_alu_ready_lv", 32'(alu_ready), 32'd0);
    next_cycle();
    ld_valid = 1'b0;
    sample();
    check("sw_le",    32'(le),    32'd0);
    check("sw_rc",    32'(rc),    32'd5);
    check("sw_C",     C,          32'hDEADBEEF);
    check("sw_count", 32'(count), 32'd1);
    next_cycle();
    sample();
    check_idle("sw_after");
    next_cycle();

    // contention: load wins, ALU follows
    alu_valid = 1'b1; alu_rd = 4'd3; alu_data = 32'h11;
    ld_valid  = 1'b1; ld_rd  = 4'd4; ld_data  = 32'h22;
    sample();
    check("ct_alu_ready0", 32'(alu_ready), 32'd0);
    check("ct_ld_ready",   32'(ld_ready),  32'd1);
    next_cycle();
    ld_valid = 1'b0;
    sample();
    check("ct_alu_ready1", 32'(alu_ready), 32'd1);
    check("ct_w1_le", 32'(le), 32'd0);
    check("ct_w1_rc", 32'(rc), 32'd4);
    check("ct_w1_C",  C,       32'h22);
    next_cycle();
    alu_valid = 1'b0;
    sample();
    check("ct_w2_le", 32'(le), 32'd0);
    check("ct_w2_rc", 32'(rc), 32'd3);
    check("ct_w2_C",  C,       32'h11);
    check("ct_w2_count", 32'(count), 32'd1);
    next_cycle();
    sample();
    check_idle("ct_after");
    next_cycle();

    // fill under stall
    stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      alu_valid = 1'b1; alu_rd = 4'(i); alu_data = 32'h100 + 32'(i);
      sample();
      check($sformatf("fill_ready%0d", i), 32'(alu_ready), (i < 4) ? 32'd1 : 32'd0);
      check($sformatf("fill_le%0d", i),    32'(le),        32'd1);
      next_cycle();
    end
    alu_valid = 1'b0;
    sample();
    check("fill_count", 32'(count), 32'd4);
    check("fill_rc",    32'(rc),    32'd0);
    check("fill_C",     C,          32'h100);
    next_cycle();
    stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sample();
      check($sformatf("drain_le%0d", k),    32'(le),    32'd0);
      check($sformatf("drain_rc%0d", k),    32'(rc),    32'(k));
      check($sformatf("drain_C%0d", k),     C,          32'h100 + 32'(k));
      check($sformatf("drain_count%0d", k), 32'(count), 32'(4 - k));
      next_cycle();
    end
    sample();
    check_idle("drain_after");
    next_cycle();

    // hazard detection
    stall = 1'b1;
    ld_valid = 1'b1; ld_rd = 4'd7; ld_data = 32'h70;
    next_cycle();
    ld_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 4'd9; alu_data = 32'h90;
    next_cycle();
    alu_valid = 1'b0;
    ra = 4'd7; rb = 4'd2;
    sample();
    check("hz_count", 32'(count), 32'd2);
    check("hz_a_7", 32'(hz_a), 32'd1);
    check("hz_b_2", 32'(hz_b), 32'd0);
    #1 rb = 4'd9; ra = 4'd3;
    #1;
    check("hz_b_9", 32'(hz_b), 32'd1);
    check("hz_a_3", 32'(hz_a), 32'd0);
    next_cycle();
    stall = 1'b0; ra = 4'd7;
    sample();
    check("hz_head_a", 32'(hz_a), 32'd1);
    check("hz_head_le", 32'(le), 32'd0);
    next_cycle();
    sample();
    check("hz_mid_a", 32'(hz_a), 32'd0);
    check("hz_mid_b", 32'(hz_b), 32'd1);
    next_cycle();
    sample();
    check("hz_end_a", 32'(hz_a), 32'd0);
    check("hz_end_b", 32'(hz_b), 32'd0);
    next_cycle();

    // wrap: 10 back-to-back accepts
    for (int i = 0; i < 10; i++) begin
      alu_valid = 1'b1; alu_rd = 4'(i); alu_data = 32'hA0 + 32'(i);
      sample();
      check($sformatf("wrap_ready%0d", i), 32'(alu_ready), 32'd1);
      check($sformatf("wrap_count%0d", i), 32'(count), (i == 0) ? 32'd0 : 32'd1);
      if (i > 0) begin
        check($sformatf("wrap_le%0d", i), 32'(le), 32'd0);
        check($sformatf("wrap_rc%0d", i), 32'(rc), 32'(i - 1));
        check($sformatf("wrap_C%0d", i),  C,       32'hA0 + 32'(i - 1));
      end
      next_cycle();
    end
    alu_valid = 1'b0;
    sample();
    check("wrap_last_rc", 32'(rc), 32'd9);
    check("wrap_last_C",  C,       32'hA9);
    check("wrap_last_le", 32'(le), 32'd0);
    next_cycle();
    sample();
    check_idle("wrap_after");
    next_cycle();

    // reset mid-operation
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_rd = 4'(8 + i); ld_data = 32'h800 + 32'(i);
      next_cycle();
    end
    ld_valid = 1'b0;
    sample();
    check("mr_count3", 32'(count), 32'd3);
    next_cycle();
    clr = 1'b1; ld_valid = 1'b1; ld_rd = 4'd12; ld_data = 32'hBAD;
    next_cycle();
    clr = 1'b0; ld_valid = 1'b0;
    sample();
    check_idle("mr_post");
    next_cycle();
    stall = 1'b0;
    sample();
    check_idle("mr_nostall");
    next_cycle();
    ld_valid = 1'b1; ld_rd = 4'd1; ld_data = 32'h55;
    next_cycle();
    ld_valid = 1'b0;
    sample();
    check("mr_new_le",    32'(le),    32'd0);
    check("mr_new_rc",    32'(rc),    32'd1);
    check("mr_new_C",     C,          32'h55);
    check("mr_new_count", 32'(count), 32'd1);
    next_cycle();
    sample();
    check_idle("mr_final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_write_queue.md
# regfile_write_queue

Write-side producer for the 16×32 register file: accepts destination/data results from the ALU and load paths, buffers them in a small in-order queue, and drains one write per cycle onto the file's C / rc / le write port. Also flags read-after-write hazards for the file's two read addresses while a write to that register is still pending. Sits between the execute/memory stages and the register file write port.

## Interface
- DEPTH, 4, queue entries; power of two, ≥ 2
- clk  in  1  clock; all state updates on rising edge
- clr  in  1  reset, synchronous, active-high
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU result accepted this edge when alu_valid & alu_ready
- alu_rd  in  4  ALU destination register
- alu_data  in  32  ALU result
- ld_valid  in  1  load result offered
- ld_ready  out  1  load result accepted this edge when ld_valid & ld_ready
- ld_rd  in  4  load destination register
- ld_data  in  32  load result
- stall  in  1  hold register-file writes this cycle
- C  out  32  write data to register file
- rc  out  4  write address to register file
- le  out  1  register-file write enable, active-low (0 = write at this edge)
- ra, rb  in  4  register-file read addresses
- hz_a, hz_b  out  1  pending write targets ra / rb
- count  out  $clog2(DEPTH)+1  entries held

## Operation
- Queue: circular buffer of {rd, data}, head/tail pointers wrap modulo DEPTH, count 0..DEPTH.
- Arbitration: at most one enqueue per cycle. Load path has priority. ld_ready = ~full. alu_ready = ~full & ~ld_valid.
- Full means count == DEPTH; a dequeue in the same cycle does not free a slot for that cycle's enqueue (ready depends only on registered count).
- Drain: le = ~(count != 0 & ~stall). C = data at head, rc = rd at head, both driven whenever count != 0; when empty C = 0, rc = 0, le = 1.
- Dequeue occurs at each edge where le == 0; head advances, count decrements.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- Ordering: writes leave in acceptance order; two pending writes to the same rd are both issued, the later one last.
- Hazard: hz_a = 1 if any valid entry (including head being written this cycle) has rd == ra; hz_b likewise for rb. Purely combinational from queue state and ra/rb.
- Stall holds queue contents and outputs C/rc; enqueue continues until full.
- Reset (clr = 1 at an edge): count = 0, head = tail = 0, all pending entries discarded; offers presented during the reset cycle are not accepted. Outputs after reset edge: le = 1, C = 0, rc = 0, hz_a = hz_b = 0, count = 0, alu_ready = ld_ready = 1 (alu_ready = ~ld_valid).

## Timing
- Latency: result accepted at edge N appears on C/rc with le = 0 during cycle N+1 (if it is head and no stall); the register file captures it at edge N+1.
- Throughput: one accept and one write per cycle sustained.
- Ready outputs are functions of registered count and ld_valid only; no combinational path from alu_valid to any output.
- hz_a/hz_b valid same cycle as ra/rb change.

## Test plan
- Single write: after reset, ld_valid=1, ld_rd=5, ld_data=0xDEADBEEF for one cycle -> next cycle le=0, rc=5, C=0xDEADBEEF, count=1; following cycle le=1, count=0.
- Contention: alu_valid=ld_valid=1 (alu rd=3 data=0x11, ld rd=4 data=0x22) -> ld accepted, alu_ready=0; next cycle alu accepted; writes appear rd 4 then rd 3.
- Fill under stall: stall=1, offer 6 ALU results -> first 4 accepted, count=4, alu_ready=0, le=1; release stall -> 4 consecutive writes in order, le=0 for exactly 4 cycles.
- Hazard: queue rd 7 and rd 9 under stall, ra=7, rb=2 -> hz_a=1, hz_b=0; rb=9 -> hz_b=1; after drain both 0.
- Wrap: 10 back-to-back accepts with no stall -> pointers wrap, all 10 writes emitted in order, count never exceeds 1.
- Reset mid-operation: count=3 under stall, assert clr one cycle with ld_valid=1 -> no write issued, le=1, count=0, that load not accepted, subsequent accepts behave as from reset.
